// File: rtl/dl_wr_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : dl_wr_port_arb
// Description : Round-robin arbiter sharing one register-file write port
//               among NUM_REQ valid/ready requesters; registered write out.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_wr_port_arb #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 32,
    parameter int ID_BITS   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_stall,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_wr_en,
    output logic [ADDR_BITS-1:0]           o_wr_addr,
    output logic [DATA_BITS-1:0]           o_wr_data,
    output logic [ID_BITS-1:0]             o_wr_id
);

    localparam logic [ID_BITS-1:0] c_LAST_ID = ID_BITS'(NUM_REQ - 1);

    logic [ID_BITS-1:0]   r_ptr;
    logic                 r_wr_en;
    logic [ADDR_BITS-1:0] r_wr_addr;
    logic [DATA_BITS-1:0] r_wr_data;
    logic [ID_BITS-1:0]   r_wr_id;

    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_BITS-1:0]   w_win_id;
    logic                 w_xfer;
    logic [ADDR_BITS-1:0] w_sel_addr;
    logic [DATA_BITS-1:0] w_sel_data;

    // Scan from the pointer, wrapping, and take the first valid requester.
    always_comb begin
        int v_idx;
        w_grant  = '0;
        w_win_id = '0;
        w_xfer   = 1'b0;
        v_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (!w_xfer && i_req_valid[v_idx]) begin
                w_xfer         = 1'b1;
                w_grant[v_idx] = 1'b1;
                w_win_id       = ID_BITS'(v_idx);
            end
        end
        if (rst || i_stall) begin
            w_grant = '0;
            w_xfer  = 1'b0;
        end
    end

    assign w_sel_addr = i_req_addr[int'(w_win_id)*ADDR_BITS +: ADDR_BITS];
    assign w_sel_data = i_req_data[int'(w_win_id)*DATA_BITS +: DATA_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_id   <= '0;
        end else if (w_xfer) begin
            r_ptr     <= (w_win_id == c_LAST_ID) ? '0 : w_win_id + 1'b1;
            // Writes to x0 complete the handshake but never reach the file.
            r_wr_en   <= (w_sel_addr != '0);
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
            r_wr_id   <= w_win_id;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign o_req_ready = w_grant;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_wr_id     = r_wr_id;

endmodule
`default_nettype wire

// File: doc/dl_wr_port_arb.md
Name: dl_wr_port_arb

Overview:
- Round-robin arbiter that shares one register-file write port between NUM_REQ requesters, e.g. ALU writeback, load unit, multiply/divide unit and CSR unit.
- Each requester uses a valid/ready handshake.
- The winning request is registered and presented as a single write command (wr_en/wr_addr/wr_data) one cycle later.
- The block sits between the execution units and the register file write port.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2..8.
- ADDR_BITS, 5, register address width.
- DATA_BITS, 32, write data width.
- ID_BITS, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  when high, no grant is issued this cycle.
- req_valid  input  NUM_REQ  per-requester valid; bit i belongs to requester i.
- req_addr  input  NUM_REQ*ADDR_BITS  packed addresses; requester i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- req_data  input  NUM_REQ*DATA_BITS  packed data; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- req_ready  output  NUM_REQ  one-hot or zero grant; combinational, same cycle as the request.
- wr_en  output  1  registered write enable to the register file.
- wr_addr  output  ADDR_BITS  registered write address.
- wr_data  output  DATA_BITS  registered write data.
- wr_id  output  ID_BITS  registered index of the requester that produced the current write.

Behaviour:
- Reset (rst=1 at a clock edge): ptr=0, wr_en=0, wr_addr=0, wr_data=0, wr_id=0. req_ready is forced to 0 while rst=1. Reset takes priority over all other activity.
- Arbitration (combinational):
  - If stall=1 or rst=1, req_ready=0.
  - Otherwise, scan requesters ptr, ptr+1, ..., ptr+NUM_REQ-1 (mod NUM_REQ). The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0.
  - At most one ready bit is set per cycle.
- Transfer: occurs for requester i when req_valid[i] && req_ready[i] at a clock edge.
- Registered output (next cycle after a transfer):
  - wr_addr=req_addr[i], wr_data=req_data[i], wr_id=i.
  - wr_en=1, unless req_addr[i]==0. A write to x0 is consumed (handshake completes) but wr_en=0. wr_addr, wr_data and wr_id still update.
- No transfer in a cycle: wr_en=0 next cycle; wr_addr, wr_data and wr_id hold their previous values.
- Latency: exactly 1 cycle from transfer to wr_en. Throughput: 1 write per cycle.
- Pointer update:
  - After a transfer from requester i, ptr <= (i+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
  - With no transfer, ptr holds.
  - stall does not modify ptr.
- Fairness: a continuously valid requester is granted within NUM_REQ non-stalled cycles.
- Requester obligations: hold valid, addr and data stable until transferred. The arbiter needs no requester to wait for ready before asserting valid. A requester may drop valid before it is granted; no state is affected.
- Simultaneous events:
  - rst and valid in the same cycle: no transfer, outputs take reset values.
  - stall and valid in the same cycle: no transfer, wr_en=0 next cycle.
- Reset mid-operation: a write registered in the previous cycle is visible for that one cycle. The reset edge then clears wr_en and no partially granted request survives. Requesters re-present after reset.
- Unused high bits of wr_id (non-power-of-2 NUM_REQ) are never driven to an out-of-range index.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, all valid=0 -> wr_en=0, wr_addr=0, wr_data=0, wr_id=0, req_ready=0000.
2. Single requester: valid=0010, addr[1]=5, data[1]=0xDEADBEEF ->
   - cycle 0: req_ready=0010.
   - cycle 1: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_id=1.
   - ptr becomes 2.
3. All requesters valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; wr_en=1 on each of cycles 1..8; wr_id follows the same sequence.
4. Pointer wrap: ptr=3 after granting 2; then valid=1001 -> requester 3 granted first, then requester 0; ptr returns to 0 then 1.
5. Stall and x0:
   - stall=1 for 3 cycles with valid=1111 -> req_ready=0, wr_en=0, ptr unchanged.
   - Then a request to addr 0 with data 0x1234 -> ready=1, next cycle wr_en=0, wr_addr=0.
6. Reset mid-stream: all valid, rst asserted on cycle 4 -> cycle-4 grant suppressed; after release, grants restart from requester 0.
